// File: rtl/bist_pkg.sv
// Shared types and default constants for the BIST pattern controller.
// The defaults describe an 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1, seeded with all ones.
package bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } bist_state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam logic [7:0]  DEF_SEED  = 8'hFF;
  localparam logic [7:0]  DEF_TAPS  = 8'hB8;

endpackage

// File: rtl/bist_lfsr_step.sv
// One combinational Galois shift step with an extra XOR input.
// The LFSR uses it with xor_i tied to zero; the MISR feeds the response word into xor_i.
module bist_lfsr_step
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic [WIDTH-1:0] xor_i,
  output logic [WIDTH-1:0] next_o
);

  assign next_o = {1'b0, state_i[WIDTH-1:1]} ^ ({WIDTH{state_i[0]}} & TAPS) ^ xor_i;

endmodule

// File: rtl/bist_pattern_ctrl.sv
// BIST source stage: streams LFSR patterns over ready/valid, compacts responses in a MISR,
// and reports signature, pass and drain timeout once per run.
module bist_pattern_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH          = DEF_WIDTH,
  parameter int unsigned      PATTERN_COUNT  = 255,
  parameter logic [WIDTH-1:0] SEED           = WIDTH'(DEF_SEED),
  parameter logic [WIDTH-1:0] TAPS           = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] GOLDEN_SIG     = {WIDTH{1'b0}},
  parameter int unsigned      TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pat_ready,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] bist_data,
  output logic             bist_valid,
  output logic             bist_sel,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [WIDTH-1:0] signature
);

  localparam int unsigned     PCW        = $clog2(PATTERN_COUNT + 1);
  localparam int unsigned     DCW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [PCW-1:0]  PAT_LAST   = PCW'(PATTERN_COUNT);
  localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(TIMEOUT_CYCLES - 1);

  bist_state_e      state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] misr_q, misr_d;
  logic [PCW-1:0]   pat_cnt_q, pat_cnt_d;
  logic [PCW-1:0]   resp_cnt_q, resp_cnt_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [WIDTH-1:0] bist_data_q, bist_data_d;
  logic             bist_valid_q, bist_valid_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [WIDTH-1:0] signature_q, signature_d;

  logic [WIDTH-1:0] lfsr_step_s;
  logic [WIDTH-1:0] misr_step_s;
  logic             resp_take_s;

  bist_lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr_step (
    .state_i (lfsr_q),
    .xor_i   ({WIDTH{1'b0}}),
    .next_o  (lfsr_step_s)
  );

  bist_lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_misr_step (
    .state_i (misr_q),
    .xor_i   (resp_data),
    .next_o  (misr_step_s)
  );

  assign resp_take_s = resp_valid && ((state_q == S_RUN) || (state_q == S_DRAIN))
                       && (resp_cnt_q < PAT_LAST);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    pat_cnt_d   = pat_cnt_q;
    resp_cnt_d  = resp_cnt_q;
    drain_cnt_d = drain_cnt_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    signature_d = signature_q;

    // The MISR is evaluated first so DRAIN sees a response landing this very cycle.
    if (resp_take_s) begin
      misr_d     = misr_step_s;
      resp_cnt_d = resp_cnt_q + PCW'(1);
    end else begin
      misr_d     = misr_q;
      resp_cnt_d = resp_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          lfsr_d     = SEED;
          misr_d     = {WIDTH{1'b0}};
          pat_cnt_d  = {PCW{1'b0}};
          resp_cnt_d = {PCW{1'b0}};
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (pat_ready) begin
          lfsr_d    = lfsr_step_s;
          pat_cnt_d = pat_cnt_q + PCW'(1);
          if (pat_cnt_d == PAT_LAST) begin
            state_d     = S_DRAIN;
            drain_cnt_d = {DCW{1'b0}};
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (resp_cnt_d == PAT_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        signature_d = misr_q;
        pass_d      = (misr_q == GOLDEN_SIG) && !timeout_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    active_d     = (state_d != S_IDLE);
    bist_valid_d = (state_d == S_RUN);
    bist_data_d  = bist_valid_d ? lfsr_d : {WIDTH{1'b0}};
    done_d       = (state_d == S_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED;
      misr_q       <= {WIDTH{1'b0}};
      pat_cnt_q    <= {PCW{1'b0}};
      resp_cnt_q   <= {PCW{1'b0}};
      drain_cnt_q  <= {DCW{1'b0}};
      bist_data_q  <= {WIDTH{1'b0}};
      bist_valid_q <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      signature_q  <= {WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      misr_q       <= misr_d;
      pat_cnt_q    <= pat_cnt_d;
      resp_cnt_q   <= resp_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      bist_data_q  <= bist_data_d;
      bist_valid_q <= bist_valid_d;
      active_q     <= active_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      signature_q  <= signature_d;
    end
  end

  assign bist_data  = bist_data_q;
  assign bist_valid = bist_valid_q;
  assign bist_sel   = active_q;
  assign busy       = active_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign signature  = signature_q;

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Bench for bist_pattern_ctrl: directed steps plus randomized runs against a queue-based model.
module tb_bist_pattern_ctrl;

  localparam int unsigned PC_A = 3;
  localparam int unsigned PC_B = 2;
  localparam int unsigned TO   = 16;
  localparam logic [7:0]  G_A  = 8'hDB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_start, a_pat_ready, a_resp_valid;
  logic [7:0] a_resp_data, a_bist_data, a_signature;
  logic       a_bist_valid, a_bist_sel, a_busy, a_done, a_pass, a_timeout;
  logic       b_start, b_pat_ready, b_resp_valid;
  logic [7:0] b_resp_data, b_bist_data, b_signature;
  logic       b_bist_valid, b_bist_sel, b_busy, b_done, b_pass, b_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  bist_pattern_ctrl #(.WIDTH(8), .PATTERN_COUNT(PC_A), .SEED(8'hFF), .TAPS(8'hB8),
                      .GOLDEN_SIG(G_A), .TIMEOUT_CYCLES(TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .pat_ready(a_pat_ready),
    .resp_valid(a_resp_valid), .resp_data(a_resp_data), .bist_data(a_bist_data),
    .bist_valid(a_bist_valid), .bist_sel(a_bist_sel), .busy(a_busy), .done(a_done),
    .pass(a_pass), .timeout(a_timeout), .signature(a_signature)
  );

  bist_pattern_ctrl #(.WIDTH(8), .PATTERN_COUNT(PC_B), .SEED(8'hFF), .TAPS(8'hB8),
                      .GOLDEN_SIG(8'h00), .TIMEOUT_CYCLES(TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .pat_ready(b_pat_ready),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .bist_data(b_bist_data),
    .bist_valid(b_bist_valid), .bist_sel(b_bist_sel), .busy(b_busy), .done(b_done),
    .pass(b_pass), .timeout(b_timeout), .signature(b_signature)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Galois step straight from the polynomial: shift right, fold in taps when bit 0 was set.
  function automatic logic [7:0] gstep(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic run_a(input string tag, input int unsigned rdy_pct, input int unsigned resp_pct,
                       input int n_resp, input int stall_at, input bit start_noise,
                       input int unsigned corrupt_pct,
                       output logic [7:0] o_sig, output logic o_pass, output logic o_to);
    logic [7:0] exp_pat, misr, r;
    logic [7:0] q[$];
    int sent, rcvd, c, drain_c, last_r, done_c, done_n, exp_done;
    bit fin, rdy, xfer, to;
    exp_pat = 8'hFF; misr = 8'h00; sent = 0; rcvd = 0; c = 0;
    drain_c = -1; last_r = -1; done_c = -1; done_n = 0; fin = 1'b0;
    to = 1'b0; o_sig = 8'h00; o_pass = 1'b0; o_to = 1'b0;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    check({tag, " start latency"}, 64'({a_busy, a_bist_sel, a_bist_valid}), 64'(3'b111));
    while (!fin && c < 300) begin
      if (a_done) begin
        if (done_c < 0) begin
          done_c = c;
          check({tag, " sel at done"}, 64'(a_bist_sel), 64'(1'b1));
        end
        done_n++;
      end
      if (done_c >= 0 && c == done_c + 1) begin
        to       = (rcvd < int'(PC_A));
        exp_done = to ? drain_c + int'(TO) : ((last_r > drain_c ? last_r : drain_c) + 1);
        o_sig = misr; o_to = to; o_pass = (misr == G_A) && !to;
        check({tag, " done pulses"}, 64'(done_n), 64'(1));
        check({tag, " done cycle"}, 64'(done_c), 64'(exp_done));
        check({tag, " sel/busy low"}, 64'({a_bist_sel, a_busy}), 64'(2'b00));
        check({tag, " signature"}, 64'(a_signature), 64'(o_sig));
        check({tag, " pass"}, 64'(a_pass), 64'(o_pass));
        check({tag, " timeout"}, 64'(a_timeout), 64'(o_to));
        fin = 1'b1;
      end else begin
        if (sent < int'(PC_A)) begin
          check({tag, " pattern"}, 64'({a_bist_valid, a_bist_data}), 64'({1'b1, exp_pat}));
        end else if (drain_c < 0) begin
          drain_c = c;
          check({tag, " drain valid/sel"}, 64'({a_bist_valid, a_bist_sel}), 64'(2'b01));
        end
        rdy = (stall_at >= 0 && c >= stall_at && c < stall_at + 5) ? 1'b0
              : ($urandom_range(99) < rdy_pct);
        xfer = rdy && (sent < int'(PC_A));
        a_pat_ready = rdy;
        if (xfer) begin
          q.push_back(exp_pat);
          exp_pat = gstep(exp_pat);
          sent++;
        end
        if (q.size() > 0 && rcvd < n_resp && (sent == int'(PC_A) || $urandom_range(99) < resp_pct)) begin
          r = q.pop_front();
          if ($urandom_range(99) < corrupt_pct) r = r ^ 8'($urandom_range(255, 1));
          a_resp_valid = 1'b1;
          a_resp_data  = r;
          misr = gstep(misr) ^ r;
          rcvd++;
          if (rcvd == int'(PC_A)) last_r = c;
        end else begin
          a_resp_valid = 1'b0;
          a_resp_data  = 8'($urandom);
        end
        a_start = start_noise && (sent < int'(PC_A)) && ($urandom_range(1) == 1);
        @(negedge clk);
        c++;
      end
    end
    if (!fin) check({tag, " done within budget"}, 64'(0), 64'(1));
    a_start = 1'b0; a_pat_ready = 1'b0; a_resp_valid = 1'b0;
  endtask

  task automatic idle_noise(input logic [7:0] sig, input logic p, input logic t);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_resp_valid = 1'b1;
      a_resp_data  = 8'($urandom);
      a_pat_ready  = 1'($urandom);
    end
    @(negedge clk);
    a_resp_valid = 1'b0; a_pat_ready = 1'b0;
    @(negedge clk);
    check("idle noise results", 64'({a_busy, a_signature, a_pass, a_timeout}),
          64'({1'b0, sig, p, t}));
  endtask

  task automatic run_b(input string tag, input logic [7:0] flip, input logic [7:0] exp_sig,
                       input logic exp_pass);
    bit seen;
    seen = 1'b0;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0; b_pat_ready = 1'b1;
    check({tag, " pattern 0"}, 64'({b_bist_valid, b_bist_data}), 64'({1'b1, 8'hFF}));
    b_resp_valid = 1'b1; b_resp_data = 8'hFF;
    @(negedge clk);
    check({tag, " pattern 1"}, 64'({b_bist_valid, b_bist_data}), 64'({1'b1, 8'hC7}));
    b_resp_data = 8'hC7 ^ flip;
    @(negedge clk);
    b_pat_ready = 1'b0; b_resp_valid = 1'b0;
    check({tag, " drain valid"}, 64'(b_bist_valid), 64'(1'b0));
    for (int k = 0; k < 20 && !seen; k++) begin
      if (b_done) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, " done seen"}, 64'(seen), 64'(1'b1));
    @(negedge clk);
    check({tag, " result"}, 64'({b_busy, b_signature, b_pass, b_timeout}),
          64'({1'b0, exp_sig, exp_pass, 1'b0}));
  endtask

  initial begin
    logic [7:0] sig;
    logic       p, t;
    rst_n = 1'b0;
    a_start = 1'b0; a_pat_ready = 1'b0; a_resp_valid = 1'b0; a_resp_data = 8'h00;
    b_start = 1'b0; b_pat_ready = 1'b0; b_resp_valid = 1'b0; b_resp_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset outputs a", 64'({a_bist_data, a_bist_valid, a_bist_sel, a_busy, a_done,
                                  a_pass, a_timeout, a_signature}), 64'(0));
    check("reset outputs b", 64'({b_bist_data, b_bist_valid, b_bist_sel, b_busy, b_done,
                                  b_pass, b_timeout, b_signature}), 64'(0));
    rst_n = 1'b1;

    run_a("loop3", 100, 100, 3, -1, 1'b0, 0, sig, p, t);
    check("loop3 golden sig", 64'(sig), 64'(8'hDB));
    check("loop3 golden pass", 64'(p), 64'(1'b1));

    run_b("pc2 clean", 8'h00, 8'h00, 1'b1);
    run_b("pc2 corrupt", 8'h01, 8'h01, 1'b0);

    run_a("stall", 100, 100, 3, 1, 1'b0, 0, sig, p, t);

    run_a("missing", 100, 100, 2, -1, 1'b0, 0, sig, p, t);
    check("missing timeout flag", 64'({p, t}), 64'(2'b01));
    idle_noise(sig, p, t);

    // Abort a run part way through and confirm the asynchronous clear.
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0; a_pat_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset a", 64'({a_bist_data, a_bist_valid, a_bist_sel, a_busy, a_done,
                                a_pass, a_timeout, a_signature}), 64'(0));
    @(negedge clk);
    a_pat_ready = 1'b0;
    rst_n = 1'b1;
    run_a("after reset", 100, 100, 3, -1, 1'b0, 0, sig, p, t);

    for (int i = 0; i < 8; i++) begin
      run_a("random", $urandom_range(100, 30), $urandom_range(100, 30),
            ($urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : int'(PC_A),
            -1, 1'b1, 30, sig, p, t);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bist_pattern_ctrl.md
Name: bist_pattern_ctrl

Overview:
- Self-test source stage that sits directly upstream of the 8-bit user/BIST select mux.
- Generates pseudo-random test patterns from a Galois LFSR and drives the mux BIST data and select lines.
- Compacts the returned responses in a MISR and compares the final signature against a golden value, reporting pass or fail.
- Ready/valid handshake on the pattern side, so a stalling downstream consumer (e.g. a serial TX) is tolerated.

Parameters:
WIDTH, 8, pattern/response/signature width
PATTERN_COUNT, 255, patterns issued per run (1..2^WIDTH-1)
SEED, 8'hFF, LFSR start value; must be nonzero
TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1)
GOLDEN_SIG, 8'h00, expected final MISR value
TIMEOUT_CYCLES, 1024, maximum cycles in DRAIN before a run is declared failed

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
pat_ready  in  1  downstream accepts bist_data this cycle
resp_valid  in  1  response word present
resp_data  in  WIDTH  response word
bist_data  out  WIDTH  current pattern, goes to the mux BIST input
bist_valid  out  1  bist_data is valid
bist_sel  out  1  mux select: 1 = BIST, 0 = user
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  result of the last run (signature match and no timeout)
timeout  out  1  last run ended by drain timeout
signature  out  WIDTH  final MISR of the last run

Behaviour:
- Reset: asynchronous, active-low.
  - All outputs are 0 while rst_n is low; the FSM is in IDLE, lfsr = SEED, misr = 0, and both counters are 0.
  - Reset mid-run aborts immediately. No done pulse is produced and results are cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start = 1.
  - On entry: lfsr <= SEED, misr <= 0, pat_cnt <= 0, resp_cnt <= 0, pass <= 0, timeout <= 0.
  - bist_sel, busy and bist_valid go high on the cycle after start is sampled. Latency is 1 cycle.
- RUN:
  - bist_valid = 1 and bist_data = lfsr.
  - A transfer occurs when bist_valid and pat_ready are both high. On each transfer the LFSR advances and pat_cnt increments.
  - While pat_ready is low, bist_data holds stable.
  - After the transfer that makes pat_cnt = PATTERN_COUNT, move to DRAIN and drop bist_valid the next cycle.
- LFSR step: next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0). The first pattern emitted is SEED.
- MISR:
  - Updated on resp_valid while in RUN or DRAIN and resp_cnt < PATTERN_COUNT.
  - misr_next = ((misr >> 1) ^ (misr[0] ? TAPS : 0)) ^ resp_data, and resp_cnt increments.
  - Responses in IDLE or DONE, and any excess responses, are ignored.
  - A response may arrive in the same cycle as its pattern transfer.
- DRAIN:
  - bist_valid = 0 and bist_sel = 1.
  - A cycle counter starts at 0 on entry.
  - When resp_cnt = PATTERN_COUNT, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with responses still missing, go to DONE with timeout = 1.
  - If the final response and the timeout occur in the same cycle, the response wins and timeout = 0.
- DONE: lasts one cycle.
  - done = 1, signature <= misr, pass <= (misr == GOLDEN_SIG) && !timeout.
  - busy and bist_sel fall on the following cycle, and the FSM returns to IDLE.
- pass, timeout and signature hold until the next start.
- start is ignored while busy, in RUN, DRAIN or DONE.
- Counter widths: $clog2(PATTERN_COUNT+1) for pat_cnt and resp_cnt, and $clog2(TIMEOUT_CYCLES) for the drain counter. No wrap is possible in legal use.

Decomposition:
- Shared package bist_pkg holds:
  - the state enum typedef;
  - localparams for the default TAPS, SEED and width.
- One natural sub-module, bist_lfsr_step: a combinational Galois step with an optional XOR input.
  - Instantiated twice: once for the LFSR (XOR input tied to 0) and once for the MISR (XOR input = resp_data).

Test Plan:
- Loopback, PATTERN_COUNT=3, pat_ready=1, resp_data=bist_data with resp_valid on each transfer:
  - bist_data sequence is FF, C7, DB.
  - Signature is DB; pass=1 with GOLDEN_SIG=DB.
  - done pulses exactly once and bist_sel falls 1 cycle after done.
- Same setup with PATTERN_COUNT=2 and GOLDEN_SIG=00 -> signature=00, pass=1. Corrupt the second response to C6 -> signature=01, pass=0.
- Backpressure: hold pat_ready=0 for 5 cycles mid-RUN -> bist_data stable and bist_valid=1 throughout; no LFSR advance, no count change.
- Missing response, PATTERN_COUNT=3, only 2 responses, TIMEOUT_CYCLES=16:
  - done arrives 16 cycles after DRAIN entry;
  - timeout=1, pass=0.
- Pulse rst_n low during RUN -> all outputs 0 asynchronously, FSM in IDLE. A later start replays FF as the first pattern.
- start asserted during RUN, and extra or late responses in IDLE -> no effect on counters, MISR or results.
